// File: rtl/exibe_sequencia.sv
// exibe_sequencia -- display side of the Genius game.
//
// Walks the jogadas memory from address 0 up to a latched limite and lights
// each word on leds for an on slot, then keeps leds dark for an off slot.
// A one-cycle pronto pulse marks the end of the whole presentation.
//
// Handshake: iniciar is a level request that is sampled only while idle
// (INICIAL). Once it is accepted, the run cannot be stopped or restarted
// except by reset. pronto is a single-cycle completion pulse and has no
// backpressure. ocupado is high in every state except INICIAL.
//
// Optional feature (macro VALIDA_ONEHOT_EN):
//   When the macro is defined, the port erro_dado is added. A word that is
//   not one-hot is blanked (leds=0000) for its on slot, and erro_dado is set.
//   erro_dado stays set until the next accepted iniciar. Timing is the same
//   in both builds.
//
// Parameters:
//   T_ON    cycles a word is lit (halved when dificuldade=1)
//   T_OFF   cycles leds stay dark after a word (halved when dificuldade=1)
//   ADDR_W  memory address width
//   Halved durations must be at least 1.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   iniciar      in   start request
//   limite       in   index of the last word to show, latched on start
//   dificuldade  in   1 = fast mode, latched on start
//   dado         in   memory read data (combinational from endereco)
//   endereco     out  registered memory address
//   leds         out  registered display output
//   ocupado      out  high while a presentation is in progress
//   pronto       out  one-cycle end-of-presentation pulse
//   db_estado    out  encoded FSM state for debug
//   erro_dado    out  (VALIDA_ONEHOT_EN only) sticky non-one-hot flag
module exibe_sequencia #(
   parameter int T_ON   = 1000,
   parameter int T_OFF  = 500,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [ADDR_W-1:0] limite,
   input  logic              dificuldade,
   input  logic [3:0]        dado,
   output logic [ADDR_W-1:0] endereco,
   output logic [3:0]        leds,
   output logic              ocupado,
   output logic              pronto,
`ifdef VALIDA_ONEHOT_EN
   output logic              erro_dado,
`endif
   output logic [3:0]        db_estado
);

   localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int CNT_W = $clog2(T_MAX + 1);

   localparam logic [CNT_W-1:0] ON_LENTO  = CNT_W'(T_ON);
   localparam logic [CNT_W-1:0] ON_RAPIDO = CNT_W'(T_ON >> 1);
   localparam logic [CNT_W-1:0] OFF_LENTO  = CNT_W'(T_OFF);
   localparam logic [CNT_W-1:0] OFF_RAPIDO = CNT_W'(T_OFF >> 1);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      CARREGA = 3'd1,
      ACENDE  = 3'd2,
      APAGA   = 3'd3,
      FIM     = 3'd4
   } estado_t;

   estado_t           estado, estado_n;
   logic [CNT_W-1:0]  contador, contador_n;
   logic [ADDR_W-1:0] limite_q, limite_n;
   logic              rapido_q, rapido_n;
   logic [ADDR_W-1:0] endereco_n;
   logic [3:0]        leds_n;
   logic              pronto_n;
   logic [CNT_W-1:0]  dur_on, dur_off;
   logic              fim_on, fim_off;
`ifdef VALIDA_ONEHOT_EN
   logic              erro_n;
   logic              dado_onehot;
`endif

   // Slot lengths come from the latched speed flag. Changing dificuldade
   // during a run therefore has no effect.
   assign dur_on  = rapido_q ? ON_RAPIDO  : ON_LENTO;
   assign dur_off = rapido_q ? OFF_RAPIDO : OFF_LENTO;

   // The counter is cleared on entry to each slot, so the slot ends after
   // the cycle in which the counter reaches duration-1.
   assign fim_on  = (contador == dur_on  - CNT_W'(1));
   assign fim_off = (contador == dur_off - CNT_W'(1));

`ifdef VALIDA_ONEHOT_EN
   assign dado_onehot = (dado != 4'b0000) && ((dado & (dado - 4'd1)) == 4'b0000);
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= INICIAL;
      end else begin
         estado <= estado_n;
      end
   end

   // Registered datapath and outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contador <= '0;
         limite_q <= '0;
         rapido_q <= 1'b0;
         endereco <= '0;
         leds     <= 4'b0000;
         pronto   <= 1'b0;
`ifdef VALIDA_ONEHOT_EN
         erro_dado <= 1'b0;
`endif
      end else begin
         contador <= contador_n;
         limite_q <= limite_n;
         rapido_q <= rapido_n;
         endereco <= endereco_n;
         leds     <= leds_n;
         pronto   <= pronto_n;
`ifdef VALIDA_ONEHOT_EN
         erro_dado <= erro_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      estado_n   = estado;
      contador_n = contador;
      limite_n   = limite_q;
      rapido_n   = rapido_q;
      endereco_n = endereco;
      leds_n     = leds;
      pronto_n   = 1'b0;
`ifdef VALIDA_ONEHOT_EN
      erro_n     = erro_dado;
`endif

      case (estado)
         INICIAL: begin
            leds_n     = 4'b0000;
            endereco_n = '0;
            contador_n = '0;
            if (iniciar) begin
               estado_n = CARREGA;
               limite_n = limite;
               rapido_n = dificuldade;
`ifdef VALIDA_ONEHOT_EN
               erro_n   = 1'b0;
`endif
            end
         end

         CARREGA: begin
            // leds doubles as the word register: the word read here is
            // held on the display for the whole on slot.
`ifdef VALIDA_ONEHOT_EN
            if (dado_onehot) begin
               leds_n = dado;
            end else begin
               leds_n = 4'b0000;
               erro_n = 1'b1;
            end
`else
            leds_n = dado;
`endif
            contador_n = '0;
            estado_n   = ACENDE;
         end

         ACENDE: begin
            if (fim_on) begin
               leds_n     = 4'b0000;
               contador_n = '0;
               estado_n   = APAGA;
            end else begin
               contador_n = contador + CNT_W'(1);
            end
         end

         APAGA: begin
            if (fim_off) begin
               contador_n = '0;
               if (endereco == limite_q) begin
                  // The address stops at limite, so it never wraps even
                  // when limite is the last address.
                  estado_n = FIM;
                  pronto_n = 1'b1;
               end else begin
                  endereco_n = endereco + ADDR_W'(1);
                  estado_n   = CARREGA;
               end
            end else begin
               contador_n = contador + CNT_W'(1);
            end
         end

         FIM: begin
            leds_n     = 4'b0000;
            endereco_n = '0;
            estado_n   = INICIAL;
         end

         default: begin
            leds_n     = 4'b0000;
            endereco_n = '0;
            contador_n = '0;
            estado_n   = INICIAL;
         end
      endcase
   end

   assign ocupado   = (estado != INICIAL);
   assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia -- bench for exibe_sequencia.
// Directed scenarios drive iniciar/limite/dificuldade against a 16-word
// jogadas memory model. Each scenario pushes its expected display events
// into a queue: word lit, word dark, and pronto, each with its address and
// cycle. A monitor pops an entry whenever leds changes or pronto pulses.
// Define VALIDA_ONEHOT_EN to also exercise the erro_dado feature.
module tb_exibe_sequencia;

   localparam int T_ON  = 1000;
   localparam int T_OFF = 500;
   localparam int W     = 30;   // {kind[1:0], leds[3:0], endereco[3:0], cycle[19:0]}

   localparam logic [1:0] EV_OFF    = 2'd0;
   localparam logic [1:0] EV_ON     = 2'd1;
   localparam logic [1:0] EV_PRONTO = 2'd2;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] limite;
   logic       dificuldade;
   logic [3:0] dado;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] db_estado;
`ifdef VALIDA_ONEHOT_EN
   logic       erro_dado;
`endif

   logic [3:0]   mem [16];
   logic [W-1:0] exp_q [$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   logic [3:0]   prev_leds = 4'b0000;

   exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .ADDR_W(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .iniciar     (iniciar),
      .limite      (limite),
      .dificuldade (dificuldade),
      .dado        (dado),
      .endereco    (endereco),
      .leds        (leds),
      .ocupado     (ocupado),
      .pronto      (pronto),
`ifdef VALIDA_ONEHOT_EN
      .erro_dado   (erro_dado),
`endif
      .db_estado   (db_estado)
   );

   assign dado = mem[endereco];

   // ---------------- clock / cycle counter / watchdog ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input logic [1:0] k, input logic [3:0] l, input logic [3:0] a, input int c);
      exp_q.push_back({k, l, a, 20'(c)});
   endtask

   function automatic logic [3:0] shown_word(input int k);
      logic [3:0] w;
      w = mem[k];
`ifdef VALIDA_ONEHOT_EN
      if (!$onehot(w)) w = 4'b0000;
`endif
      return w;
   endfunction

   function automatic int dur_on(input bit d);
      return d ? (T_ON >> 1) : T_ON;
   endfunction

   function automatic int period(input bit d);
      return (d ? (T_ON >> 1) : T_ON) + (d ? (T_OFF >> 1) : T_OFF) + 1;
   endfunction

   // Expected events for a full presentation accepted at edge s.
   task automatic push_run(input int lim, input bit d, input int s);
      int p;
      logic [3:0] w;
      p = period(d);
      for (int k = 0; k <= lim; k++) begin
         w = shown_word(k);
         if (w != 4'b0000) begin
            push_ev(EV_ON,  w,       4'(k), s + 1 + k * p);
            push_ev(EV_OFF, 4'b0000, 4'(k), s + 1 + k * p + dur_on(d));
         end
      end
      push_ev(EV_PRONTO, 4'b0000, 4'(lim), s + (lim + 1) * p);
   endtask

   // Raises iniciar. Returns the number of the edge that samples it.
   task automatic start(input logic [3:0] lim, input logic d, output int s);
      @(negedge clock);
      limite      = lim;
      dificuldade = d;
      iniciar     = 1'b1;
      @(posedge clock);
      #1 s = cyc;
   endtask

   task automatic release_start();
      @(negedge clock);
      iniciar = 1'b0;
   endtask

   task automatic wait_pronto(input int budget, input string name);
      int  n;
      bit  found;
      n = 0;
      found = 1'b0;
      while (!found && n < budget) begin
         @(negedge clock);
         n++;
         if (pronto === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s: pronto got 0 after %0d cycles, required 1", name, budget);
      end
   endtask

   task automatic idle_checks(input string name);
      @(posedge clock);
      #1;
      check({name, "_ocupado"},   32'(ocupado),   32'd0);
      check({name, "_db_estado"}, 32'(db_estado), 32'd0);
      check({name, "_endereco"},  32'(endereco),  32'd0);
      check({name, "_leds"},      32'(leds),      32'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      logic [W-1:0] got, exp;
      logic [1:0]   kind;
      if (pronto === 1'b1 || leds !== prev_leds) begin
         if (pronto === 1'b1) kind = EV_PRONTO;
         else if (leds != 4'b0000) kind = EV_ON;
         else kind = EV_OFF;
         got = {kind, leds, endereco, 20'(cyc)};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got kind=%0d leds=%b end=%0d cyc=%0d, required no event",
                     got[29:28], got[27:24], got[23:20], got[19:0]);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL event: got kind=%0d leds=%b end=%0d cyc=%0d, required kind=%0d leds=%b end=%0d cyc=%0d",
                        got[29:28], got[27:24], got[23:20], got[19:0],
                        exp[29:28], exp[27:24], exp[23:20], exp[19:0]);
            end
         end
      end
      prev_leds = leds;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int s, s2, p, n;

      mem = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
              4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset       = 1'b0;
      iniciar     = 1'b0;
      limite      = 4'd0;
      dificuldade = 1'b0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("reset_leds",      32'(leds),      32'd0);
      check("reset_endereco",  32'(endereco),  32'd0);
      check("reset_ocupado",   32'(ocupado),   32'd0);
      check("reset_pronto",    32'(pronto),    32'd0);
      check("reset_db_estado", 32'(db_estado), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);

      // 1) single word, slow mode
      start(4'd0, 1'b0, s);
      push_run(0, 1'b0, s);
      release_start();
      repeat (5) @(posedge clock);
      #1;
      check("t1_ocupado_run", 32'(ocupado),   32'd1);
      check("t1_estado_run",  32'(db_estado), 32'd2);
      check("t1_leds_run",    32'(leds),      32'b0001);
      wait_pronto(2000, "t1_pronto");
      idle_checks("t1_idle");

      // 2) four words
      start(4'd3, 1'b0, s);
      push_run(3, 1'b0, s);
      release_start();
      wait_pronto(7000, "t2_pronto");
      idle_checks("t2_idle");

      // 3) fast mode, all 8 words, inputs toggled mid-run
      start(4'd7, 1'b1, s);
      push_run(7, 1'b1, s);
      release_start();
      for (int i = 0; i < 4; i++) begin
         repeat (300) @(negedge clock);
         dificuldade = ~dificuldade;
         limite      = limite + 4'd5;
      end
      wait_pronto(7000, "t3_pronto");
      idle_checks("t3_idle");

      // 4) iniciar held for 5 edges and re-pulsed during ACENDE
      start(4'd2, 1'b0, s);
      push_run(2, 1'b0, s);
      repeat (4) @(posedge clock);
      release_start();
      repeat (200) @(negedge clock);
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      wait_pronto(5000, "t4_pronto");
      idle_checks("t4_idle");
      repeat (1600) @(negedge clock);

      // 5) iniciar still high on return to INICIAL starts a new run
      p = period(1'b0);
      start(4'd0, 1'b0, s);
      s2 = s + p + 2;
      push_run(0, 1'b0, s);
      push_run(0, 1'b0, s2);
      repeat (p + 2) @(posedge clock);
      release_start();
      wait_pronto(2000, "t5_pronto2");
      idle_checks("t5_idle");

      // 6) reset during word 2 ACENDE
      start(4'd3, 1'b0, s);
      for (int k = 0; k < 2; k++) begin
         push_ev(EV_ON,  mem[k],  4'(k), s + 1 + k * p);
         push_ev(EV_OFF, 4'b0000, 4'(k), s + 1 + k * p + T_ON);
      end
      push_ev(EV_ON, mem[2], 4'd2, s + 1 + 2 * p);
      release_start();
      n = 1 + 2 * p + 100;
      repeat (n) @(posedge clock);
      #2 reset = 1'b0;
      push_ev(EV_OFF, 4'b0000, 4'd0, s + n);
      #1;
      check("t6_leds",     32'(leds),     32'd0);
      check("t6_endereco", 32'(endereco), 32'd0);
      check("t6_ocupado",  32'(ocupado),  32'd0);
      check("t6_pronto",   32'(pronto),   32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2 * p) @(negedge clock);

      // 7) limite at the last address, fast mode
      start(4'd15, 1'b1, s);
      push_run(15, 1'b1, s);
      release_start();
      wait_pronto(13000, "t7_pronto");
      idle_checks("t7_idle");

`ifdef VALIDA_ONEHOT_EN
      // 8) non-one-hot word at address 2
      mem[2] = 4'b0011;
      start(4'd3, 1'b0, s);
      push_run(3, 1'b0, s);
      release_start();
      repeat (p + 10) @(posedge clock);
      #1 check("t8_erro_slot1", 32'(erro_dado), 32'd0);
      wait_pronto(7000, "t8_pronto");
      idle_checks("t8_idle");
      check("t8_erro_sticky", 32'(erro_dado), 32'd1);
      mem[2] = 4'b0100;
      start(4'd0, 1'b0, s);
      push_run(0, 1'b0, s);
      check("t8_erro_cleared", 32'(erro_dado), 32'd0);
      release_start();
      wait_pronto(2000, "t8_pronto2");
`endif

      repeat (5) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
